// File: rtl/acpi_pkg.sv
// Shared definitions for the RGB plane packer: geometry defaults, widths,
// FSM state encoding and the per-channel saturation helper.
package acpi_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int ADDR_W    = 14;
  localparam int PLANE_W   = 14;
  localparam int PIX_W     = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Two's complement plane word -> 8-bit channel, saturating at 0 and 255.
  function automatic logic [7:0] clamp_ch(input logic [PLANE_W-1:0] v);
    logic [7:0] r;
    if (v[PLANE_W-1])
      r = 8'h00;
    else if (|v[PLANE_W-2:8])
      r = 8'hFF;
    else
      r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/rgb_out_fifo.sv
// Small output FIFO for packed pixels plus last flag; exposes its occupancy
// so the reader can throttle plane reads against free space.
module rgb_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 25,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/rgb_packer.sv
// Reads three 14-bit colour planes in raster order and emits 24-bit RGB pixels
// over valid/ready. Define RGB_PACK_CLAMP_EN to saturate channels instead of truncating.
module rgb_packer
  import acpi_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PLANE_W-1:0] g_rdata,
  input  logic [PLANE_W-1:0] b_rdata,
  input  logic [PLANE_W-1:0] r_rdata,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_last,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] iss;
  logic [RD_LAT-1:0] iss_last;
  logic [CNT_W-1:0]  fifo_count;
  logic [2:0]        inflight;
  logic [3:0]        occ;
  logic              pop;
  logic              issue;
  logic [7:0]        r8, g8, b8;
  logic [PIX_W:0]    fifo_rdata;

  assign pop = pix_valid & pix_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 3'(iss[i]);
  end

  // A slot freed by this cycle's pop may be reused by this cycle's read,
  // which is what sustains one pixel per cycle with a RD_LAT+1 deep FIFO.
  assign occ   = 4'(fifo_count) + 4'(inflight);
  assign issue = (state == ST_READ) && (occ < 4'(DEPTH) + 4'(pop));

  assign rd_en   = issue;
  assign rd_addr = addr;

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            iss[0]      <= 1'b0;
            iss_last[0] <= 1'b0;
          end else begin
            iss[0]      <= issue;
            iss_last[0] <= issue && (addr == LAST_ADDR);
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            iss[gi]      <= 1'b0;
            iss_last[gi] <= 1'b0;
          end else begin
            iss[gi]      <= iss[gi-1];
            iss_last[gi] <= iss_last[gi-1];
          end
        end
      end
    end
  endgenerate

`ifdef RGB_PACK_CLAMP_EN
  assign r8 = clamp_ch(r_rdata);
  assign g8 = clamp_ch(g_rdata);
  assign b8 = clamp_ch(b_rdata);
`else
  logic unused_hi;
  assign unused_hi = ^{r_rdata[PLANE_W-1:8], g_rdata[PLANE_W-1:8], b_rdata[PLANE_W-1:8]};
  assign r8 = r_rdata[7:0];
  assign g8 = g_rdata[7:0];
  assign b8 = b_rdata[7:0];
`endif

  rgb_out_fifo #(
    .DEPTH (DEPTH),
    .W     (PIX_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (iss[RD_LAT-1]),
    .wdata ({r8, g8, b8, iss_last[RD_LAT-1]}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign pix_valid = (fifo_count != '0);
  assign pix_data  = fifo_rdata[PIX_W:1];
  assign pix_last  = fifo_rdata[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_READ;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (addr == LAST_ADDR) state <= ST_DRAIN;
            else                   addr  <= addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Finish as the final pixel is taken, so done follows the last handshake directly.
          if ((iss == '0) && (fifo_count == CNT_W'(pop))) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_packer.sv
// Directed bench for rgb_packer: full frames, backpressure, stall throttling,
// mid-frame reset and channel conversion (expectation follows RGB_PACK_CLAMP_EN).
module tb_rgb_packer;

  localparam int RD_LAT = 1;
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int N      = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [13:0] g_rdata, b_rdata, r_rdata;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_mode = 0;

  int          n_xfer, n_bad, n_last_bad, n_unstable, n_done, done_cyc, last_hs, first_valid;
  logic [23:0] pix5, first_data;

  always #5 clk = ~clk;

  rgb_packer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .g_rdata(g_rdata), .b_rdata(b_rdata), .r_rdata(r_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  // Plane memory model returning {r,g,b} RD_LAT cycles after rd_en.
  function automatic logic [41:0] plane(input logic [13:0] a);
    if (mem_mode == 0) return {6'd0, a[7:0], 14'h0010, 14'h0020};
    return {14'h0100, 14'h3FFF, 14'h00FF};
  endfunction

  logic [41:0] rdpipe [RD_LAT];
  always @(posedge clk) begin
    rdpipe[0] <= rd_en ? plane(rd_addr) : 42'd0;
    for (int i = 1; i < RD_LAT; i++) rdpipe[i] <= rdpipe[i-1];
  end
  assign {r_rdata, g_rdata, b_rdata} = rdpipe[RD_LAT-1];

  function automatic logic [23:0] exp_pix(input int idx);
    logic [13:0] a;
    a = 14'(idx);
    if (mem_mode == 0) return {a[7:0], 8'h10, 8'h20};
`ifdef RGB_PACK_CLAMP_EN
    return 24'hFF00FF;
`else
    return 24'h00FFFF;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  // rmode 0: ready always high; rmode 1: ready toggles 1-0-1-0.
  task automatic run_frame(input int rmode, input int stop_after, input int restart_at, input int max_cyc);
    logic [24:0] held;
    bit          held_pend;
    n_xfer = 0; n_bad = 0; n_last_bad = 0; n_unstable = 0; n_done = 0;
    done_cyc = -100; last_hs = -100; first_valid = -1;
    held_pend = 0; held = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      start     = (cyc == restart_at);
      pix_ready = (rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (done) begin n_done++; done_cyc = cyc; end
      if (held_pend && (!pix_valid || {pix_last, pix_data} !== held)) n_unstable++;
      if (pix_valid && first_valid < 0) first_valid = cyc;
      if (pix_valid && pix_ready) begin
        if (pix_data !== exp_pix(n_xfer)) n_bad++;
        if (pix_last !== (n_xfer == N - 1)) n_last_bad++;
        if (n_xfer == 0) first_data = pix_data;
        if (n_xfer == 5) pix5 = pix_data;
        last_hs = cyc;
        n_xfer++;
      end
      held_pend = pix_valid && !pix_ready;
      held      = {pix_last, pix_data};
      if (stop_after > 0 && n_xfer >= stop_after) break;
      if (n_done > 0 && cyc >= done_cyc + 5) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int n_rd;
    int n_done_abort;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_pix_last", 32'(pix_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    $display("reset released, outputs checked");

    // Full frame, ready high, second start at cycle 100 must be ignored
    mem_mode  = 0;
    pix_ready = 1'b1;
    pulse_start();
    run_frame(0, 0, 100, N + 200);
    $display("frame A: %0d transfers, %0d done pulses, first valid at cycle %0d", n_xfer, n_done, first_valid);
    check("A_first_valid_latency", 32'(first_valid), RD_LAT + 1);
    check("A_transfers", 32'(n_xfer), N);
    check("A_pixel_order", 32'(n_bad), 0);
    check("A_pix_last_position", 32'(n_last_bad), 0);
    check("A_pixel5", 32'(pix5), 32'h051020);
    check("A_done_pulses", 32'(n_done), 1);
    check("A_done_after_last_hs", 32'(done_cyc), 32'(last_hs + 1));
    check("A_busy_after_done", 32'(busy), 0);

    // Full frame with ready toggling
    pulse_start();
    run_frame(1, 0, -1, 2 * N + 200);
    $display("frame B: %0d transfers, %0d stall violations, %0d done pulses", n_xfer, n_unstable, n_done);
    check("B_transfers", 32'(n_xfer), N);
    check("B_pixel_order", 32'(n_bad), 0);
    check("B_hold_stable", 32'(n_unstable), 0);
    check("B_done_pulses", 32'(n_done), 1);

    // Ready low after start: reads throttle at FIFO depth
    pix_ready = 1'b0;
    pulse_start();
    n_rd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start     = 1'b0;
      pix_ready = 1'b0;
      if (rd_en) n_rd++;
    end
    $display("stall: %0d reads issued, rd_addr=%0d", n_rd, rd_addr);
    check("stall_reads_issued", 32'(n_rd), RD_LAT + 1);
    check("stall_rd_addr", 32'(rd_addr), RD_LAT + 1);
    check("stall_pix_valid", 32'(pix_valid), 1);
    check("stall_pix_data", 32'(pix_data), 32'h001020);
    check("stall_busy", 32'(busy), 1);
    run_frame(0, 1000, -1, 3000);
    $display("resume: %0d transfers", n_xfer);
    check("resume_transfers", 32'(n_xfer), 1000);
    check("resume_pixel_order", 32'(n_bad), 0);

    // Asynchronous reset at pixel 1000
    #2 rst = 1'b1;
    #1;
    check("abort_rd_en", 32'(rd_en), 0);
    check("abort_rd_addr", 32'(rd_addr), 0);
    check("abort_pix_valid", 32'(pix_valid), 0);
    check("abort_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    n_done_abort = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done_abort++;
    end
    $display("abort: %0d done pulses after reset", n_done_abort);
    check("abort_no_done", 32'(n_done_abort), 0);
    pulse_start();
    run_frame(0, 5, -1, 100);
    $display("restart: first pixel 0x%06h", first_data);
    check("restart_first_pixel", 32'(first_data), 32'h001020);
    check("restart_pixel_order", 32'(n_bad), 0);

    // Channel conversion with out-of-range plane words
    @(negedge clk);
    rst = 1'b1;
    mem_mode = 1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    run_frame(0, 3, -1, 100);
    $display("convert: pixel 0x%06h", first_data);
    check("convert_pixel", 32'(first_data), 32'(exp_pix(0)));
    check("convert_transfers", 32'(n_xfer), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_packer.md
RGB_PACKER -- requirements
Module: rgb_packer

Interface
REQ-001 Parameter IMG_W, default 128: image width in pixels.
REQ-002 Parameter IMG_H, default 128: image height in pixels; IMG_W*IMG_H SHALL NOT exceed 16384.
REQ-003 Parameter RD_LAT, default 1: plane-memory read latency in cycles, range 1..3.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse; begins one frame readout.
REQ-008 rd_en  out  1  read strobe to green, blue and red plane memories.
REQ-009 rd_addr  out  14  shared raster address: row*IMG_W+col.
REQ-010 g_rdata  in  14  green plane word, valid RD_LAT cycles after rd_en.
REQ-011 b_rdata  in  14  blue plane word, same timing.
REQ-012 r_rdata  in  14  red plane word, same timing.
REQ-013 pix_valid  out  1  output pixel valid.
REQ-014 pix_ready  in  1  downstream accept.
REQ-015 pix_data  out  24  {R[23:16],G[15:8],B[7:0]}.
REQ-016 pix_last  out  1  marks pixel at address IMG_W*IMG_H-1.
REQ-017 busy  out  1  high from accepted start to done.
REQ-018 done  out  1  one-cycle pulse at frame end.

Function
REQ-019 FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on start; READ->DRAIN after last read issued; DRAIN->DONE when output FIFO and in-flight pipe are empty; DONE->IDLE next cycle, done=1 only in DONE.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 rd_addr SHALL start at 0 and increment by 1 per issued read, stopping at IMG_W*IMG_H-1 with no wrap.
REQ-022 A read SHALL be issued only when FIFO occupancy plus in-flight reads is below FIFO depth RD_LAT+1.
REQ-023 With pix_ready held high, throughput SHALL be one pixel per cycle; first pix_valid RD_LAT+1 cycles after start.
REQ-024 Per channel, 14-bit input is two's complement: negative -> 0x00, >255 -> 0xFF, else low 8 bits.
REQ-025 pix_data and pix_last SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-026 Transfer occurs only on pix_valid&pix_ready; simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-027 Read data returning with a full FIFO SHALL be impossible by REQ-022; no pixel is dropped or duplicated.
REQ-028 Exactly IMG_W*IMG_H pixels per frame, in raster order.

Reset
REQ-029 On rst: state IDLE; rd_en, rd_addr, pix_valid, pix_data, pix_last, busy, done all 0; FIFO and in-flight pipe emptied.
REQ-030 rst mid-frame SHALL abort the frame; no done pulse; next start restarts at address 0.

Configuration
REQ-031 With RGB_PACK_CLAMP_EN defined, REQ-024 saturation applies.
REQ-032 Without RGB_PACK_CLAMP_EN, each channel SHALL be bits [7:0] of the input, unsaturated; all other behaviour identical.

Structure
REQ-033 Shared package acpi_pkg: IMG_W/IMG_H defaults, ADDR_W=14, PLANE_W=14, FSM state enum, channel-clamp function.
REQ-034 Sub-module rgb_out_fifo: (RD_LAT+1)-entry, 24+1-bit FIFO with count output.

Verification
REQ-035 start, pix_ready=1, planes R=addr[7:0], G=0x10, B=0x20 -> 16384 pixels, pixel 5 = 0x051020, pix_last only on pixel 16383, done one cycle after final handshake.
REQ-036 g_rdata=0x3FFF (-1), r_rdata=0x0100, b_rdata=0x00FF -> pix_data=0xFF00FF with clamp; 0x00FFFF without RGB_PACK_CLAMP_EN.
REQ-037 pix_ready toggling 1-0-1-0 -> no loss or duplication; pix_data stable across stalled cycles; 16384 transfers total.
REQ-038 pix_ready=0 for 50 cycles after start -> at most RD_LAT+1 reads issued; rd_addr stops at RD_LAT+1.
REQ-039 rst asserted at pixel 1000, then start -> first output is address 0, no done from aborted frame.
REQ-040 second start while busy -> ignored; exactly one frame and one done pulse.
